mult_dispatch: RTL

MULT_DISPATCH -- requirements
Module: mult_dispatch

---
 rtl/mult_dispatch_if.sv | 35 +++
 rtl/mult_dispatch.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mult_dispatch_if.sv
// Operand/result bus between producer, dispatcher, multiplier core and result consumer.
interface mult_dispatch_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_multiplier;
    logic [7:0]    in_multiplicand;
    logic          mult_reset;
    logic [7:0]    multiplier;
    logic [7:0]    multiplicand;
    logic [15:0]   product;
    logic          done;
    logic          res_valid;
    logic          res_ready;
    logic [15:0]   res_product;
    logic          res_timeout;
    logic [CW-1:0] fifo_count;

    // Dispatcher side.
    modport slave (
        input  in_valid, in_multiplier, in_multiplicand, product, done, res_ready,
        output in_ready, mult_reset, multiplier, multiplicand, res_valid, res_product,
               res_timeout, fifo_count
    );

    // Producer / core / consumer side.
    modport master (
        output in_valid, in_multiplier, in_multiplicand, product, done, res_ready,
        input  in_ready, mult_reset, multiplier, multiplicand, res_valid, res_product,
               res_timeout, fifo_count
    );
endinterface

// File: rtl/mult_dispatch.sv
// Queues signed operand pairs and sequences them one at a time through an external
// multiplier core, with a timeout guard and a held result register.
module mult_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_dispatch_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    fifo_mplr [DEPTH];
    logic [7:0]    fifo_mcnd [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic          in_ready_q;
    logic          push;
    logic          pop;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nx;
    logic          capture;
    logic          abort;
    logic          mult_reset_q;
    logic          mult_reset_nx;
    logic          res_valid_q;
    logic          res_valid_nx;
    logic [15:0]   res_product_q;
    logic [15:0]   res_product_nx;
    logic          res_timeout_q;
    logic          res_timeout_nx;
    logic [7:0]    mplr_q;
    logic [7:0]    mcnd_q;

    // Ready is registered, so a full FIFO never takes a push even if it pops that cycle.
    assign push     = bus.in_valid && in_ready_q;
    assign pop      = (state == IDLE) && (count != '0);
    assign count_nx = count + CW'(push) - CW'(pop);

    assign bus.in_ready     = in_ready_q;
    assign bus.fifo_count   = count;
    assign bus.mult_reset   = mult_reset_q;
    assign bus.multiplier   = mplr_q;
    assign bus.multiplicand = mcnd_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_product  = res_product_q;
    assign bus.res_timeout  = res_timeout_q;

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mplr[wr_ptr] <= bus.in_multiplier;
            fifo_mcnd[wr_ptr] <= bus.in_multiplicand;
        end
    end

    // FIFO pointers (wrap naturally at DEPTH), occupancy and ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_nx;
            in_ready_q <= (count_nx < CW'(DEPTH));
        end
    end

    // Operand registers: loaded on pop, held through LOAD/RUN/HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mplr_q <= '0;
            mcnd_q <= '0;
        end else if (pop) begin
            mplr_q <= fifo_mplr[rd_ptr];
            mcnd_q <= fifo_mcnd[rd_ptr];
        end
    end

    // State and RUN timer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    // Next state; done is ignored in the first RUN cycle since it may be left over.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        capture  = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: if (pop) state_nx = LOAD;
            LOAD: begin
                state_nx = RUN;
                timer_nx = '0;
            end
            RUN: begin
                timer_nx = timer + TW'(1);
                if ((timer != '0) && bus.done) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    abort    = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        mult_reset_nx  = (state_nx == LOAD);
        res_valid_nx   = (state_nx == HOLD);
        res_product_nx = res_product_q;
        res_timeout_nx = res_timeout_q;
        if (capture) begin
            res_product_nx = bus.product;
            res_timeout_nx = 1'b0;
        end else if (abort) begin
            res_product_nx = '0;
            res_timeout_nx = 1'b1;
        end
    end

    // Output registers; mult_reset holds the core in restart while reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_reset_q  <= 1'b1;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            mult_reset_q  <= mult_reset_nx;
            res_valid_q   <= res_valid_nx;
            res_product_q <= res_product_nx;
            res_timeout_q <= res_timeout_nx;
        end
    end
endmodule
